// File: rtl/soc_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package soc_timer_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;
  localparam logic [2:0] REG_CMP_L    = 3'd6;
  localparam logic [2:0] REG_CMP_H    = 3'd7;

  localparam int CTL_ITO     = 0;
  localparam int CTL_CONT    = 1;
  localparam int CTL_START   = 2;
  localparam int CTL_STOP    = 3;
  localparam int CTL_PWM     = 4;
  localparam int CTL_PRE_LSB = 8;

  localparam int STS_TO  = 0;
  localparam int STS_RUN = 1;

endpackage

// File: rtl/soc_timer_multi_if.sv
// Avalon-MM slave bus bundle for the multi-channel timer.
interface soc_timer_multi_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_timer_channel.sv
// One timer channel: registers, prescaler, down counter, PWM compare and read mux.
module soc_timer_channel
  import soc_timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr,
  input  logic [2:0]  reg_addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq,
  output logic        pwm
);

  localparam int HI_W = CNT_W - 16;

  logic [CNT_W-1:0] period, cnt, cmp, snap;
  logic [7:0]       pre, presc;
  logic             ito, cont, pwm_en;
  logic             to, run, force_reload;
  logic             tick;

  // Upper half only keeps the bits that exist above bit 15.
  function automatic logic [CNT_W-1:0] set_half(input logic [CNT_W-1:0] cur,
                                                input logic hi, input logic [15:0] d);
    logic [CNT_W-1:0] r;
    r = cur;
    if (hi) r[CNT_W-1:16] = d[HI_W-1:0];
    else    r[15:0]       = d;
    return r;
  endfunction

  function automatic logic [15:0] get_half(input logic [CNT_W-1:0] v, input logic hi);
    logic [15:0] r;
    r = '0;
    if (hi) r[HI_W-1:0] = v[CNT_W-1:16];
    else    r           = v[15:0];
    return r;
  endfunction

  assign tick = run && (presc == pre);
  assign irq  = to & ito;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period       <= CNT_W'(RESET_PERIOD);
      cnt          <= CNT_W'(RESET_PERIOD);
      cmp          <= '0;
      snap         <= '0;
      pre          <= '0;
      presc        <= '0;
      ito          <= 1'b0;
      cont         <= 1'b0;
      pwm_en       <= 1'b0;
      to           <= 1'b0;
      run          <= 1'b0;
      force_reload <= 1'b0;
      pwm          <= 1'b0;
    end else begin
      force_reload <= wr && (reg_addr == REG_PERIOD_L || reg_addr == REG_PERIOD_H);

      if (run) presc <= (presc == pre) ? 8'd0 : presc + 8'd1;

      if (tick) begin
        if (cnt == '0) begin
          to  <= 1'b1;
          cnt <= period;
          if (!cont) run <= 1'b0;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end

      if (force_reload) begin
        cnt   <= period;
        run   <= 1'b0;
        presc <= '0;
      end

      // Bus writes come last so a TO clear or START overrides same-cycle events.
      if (wr) begin
        case (reg_addr)
          REG_STATUS:   to <= 1'b0;
          REG_CONTROL: begin
            ito    <= wdata[CTL_ITO];
            cont   <= wdata[CTL_CONT];
            pwm_en <= wdata[CTL_PWM];
            pre    <= wdata[CTL_PRE_LSB +: 8];
            if (wdata[CTL_START]) begin
              run   <= 1'b1;
              presc <= '0;
            end else if (wdata[CTL_STOP]) begin
              run <= 1'b0;
            end
          end
          REG_PERIOD_L: period <= set_half(period, 1'b0, wdata);
          REG_PERIOD_H: period <= set_half(period, 1'b1, wdata);
          REG_SNAP_L,
          REG_SNAP_H:   snap   <= cnt;
          REG_CMP_L:    cmp    <= set_half(cmp, 1'b0, wdata);
          REG_CMP_H:    cmp    <= set_half(cmp, 1'b1, wdata);
          default: ;
        endcase
      end

      pwm <= pwm_en & run & (cnt < cmp);
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_addr)
      REG_STATUS: begin
        rdata[STS_TO]  = to;
        rdata[STS_RUN] = run;
      end
      REG_CONTROL: begin
        rdata[CTL_ITO]           = ito;
        rdata[CTL_CONT]          = cont;
        rdata[CTL_PWM]           = pwm_en;
        rdata[CTL_PRE_LSB +: 8]  = pre;
      end
      REG_PERIOD_L: rdata = get_half(period, 1'b0);
      REG_PERIOD_H: rdata = get_half(period, 1'b1);
      REG_SNAP_L:   rdata = get_half(snap, 1'b0);
      REG_SNAP_H:   rdata = get_half(snap, 1'b1);
      REG_CMP_L:    rdata = get_half(cmp, 1'b0);
      REG_CMP_H:    rdata = get_half(cmp, 1'b1);
      default:      rdata = '0;
    endcase
  end

endmodule

// File: rtl/soc_timer_multi.sv
// Multi-channel Avalon-MM interval/PWM timer: channel decode, read mux, irq OR.
module soc_timer_multi
  import soc_timer_pkg::*;
#(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 49999
) (
  input  logic              clk,
  input  logic              reset_n,
  soc_timer_multi_if.slave  bus,
  output logic              irq,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int ADDR_W = 3 + $clog2(NUM_CH);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0]   ch;
  logic [15:0]       rdata [NUM_CH];
  logic [NUM_CH-1:0] irq_ch;
  logic [15:0]       rd_mux;

  if (NUM_CH > 1) begin : g_dec
    assign ch = bus.address[ADDR_W-1:3];
  end else begin : g_dec_single
    assign ch = 1'b0;
  end

  // Channel indices with no instance match nothing: writes drop, reads give 0.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    soc_timer_channel #(
      .CNT_W        (CNT_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr       (bus.chipselect && !bus.write_n && (ch == CH_W'(i))),
      .reg_addr (bus.address[2:0]),
      .wdata    (bus.writedata),
      .rdata    (rdata[i]),
      .irq      (irq_ch[i]),
      .pwm      (pwm_out[i])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == CH_W'(i)) rd_mux = rdata[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_mux;
  end

  assign irq = |irq_ch;

endmodule

// File: tb/tb_soc_timer_multi.sv
// Directed bench for soc_timer_multi: register map, timeouts, PWM, snapshot, async reset.
module tb_soc_timer_multi;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       irq;
  logic [1:0] pwm_out;
  int         n_assert = 0;
  int         n_fail   = 0;

  soc_timer_multi_if #(.ADDR_W(4)) bus ();

  soc_timer_multi #(
    .NUM_CH       (2),
    .CNT_W        (24),
    .RESET_PERIOD (49999)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end just after a falling edge.
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    int hi_cnt;
    int first_hi;

    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    #3;
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_pwm", 32'(pwm_out), 32'h0);
    chk("reset_readdata", 32'(bus.readdata), 32'h0);
    step(2);
    reset_n = 1'b1;

    rd(4'd2, d); chk("ch0_period_l_reset", 32'(d), 32'hC34F);
    rd(4'd3, d); chk("ch0_period_h_reset", 32'(d), 32'h0000);
    rd(4'd0, d); chk("ch0_status_reset", 32'(d), 32'h0000);

    // ch1 continuous timeout every 10 cycles with interrupt
    wr(4'd10, 16'd9);
    wr(4'd11, 16'd0);
    wr(4'd9, 16'h0007);
    step(9);  chk("ch1_irq_before_to", 32'(irq), 32'h0);
    step(1);  chk("ch1_irq_at_to", 32'(irq), 32'h1);
    wr(4'd8, 16'h0000);
    chk("ch1_irq_cleared", 32'(irq), 32'h0);
    step(8);  chk("ch1_irq_before_to2", 32'(irq), 32'h0);
    step(1);  chk("ch1_irq_at_to2", 32'(irq), 32'h1);
    wr(4'd8, 16'h0000);
    wr(4'd9, 16'h0008);

    // ch0 one-shot, prescaler 3
    wr(4'd2, 16'd4);
    wr(4'd3, 16'd0);
    wr(4'd1, 16'h0305);
    step(19); chk("ch0_oneshot_irq_early", 32'(irq), 32'h0);
    step(1);  chk("ch0_oneshot_irq", 32'(irq), 32'h1);
    rd(4'd0, d); chk("ch0_oneshot_status", 32'(d), 32'h0001);
    wr(4'd4, 16'h0000);
    rd(4'd4, d); chk("ch0_oneshot_cnt_held", 32'(d), 32'd4);
    rd(4'd5, d); chk("ch0_oneshot_cnt_hi", 32'(d), 32'd0);
    wr(4'd0, 16'h0000);

    // ch0 PWM, period 99, compare 25
    wr(4'd2, 16'd99);
    wr(4'd3, 16'd0);
    wr(4'd6, 16'd25);
    wr(4'd7, 16'd0);
    wr(4'd1, 16'h0016);
    hi_cnt   = 0;
    first_hi = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (pwm_out[0]) begin
        hi_cnt++;
        if (first_hi == 0) first_hi = k;
      end
    end
    chk("pwm_high_count", 32'(hi_cnt), 32'd25);
    chk("pwm_first_high", 32'(first_hi), 32'd76);
    step(90);
    chk("pwm_high_before_reload", 32'(pwm_out[0]), 32'h1);
    wr(4'd2, 16'd99);
    step(2);
    chk("pwm_low_after_reload", 32'(pwm_out[0]), 32'h0);
    rd(4'd0, d); chk("pwm_status_after_reload", 32'(d), 32'h0001);
    wr(4'd0, 16'h0000);

    // ch1 snapshot of a running counter
    wr(4'd10, 16'd1000);
    wr(4'd11, 16'd0);
    wr(4'd9, 16'h0006);
    step(100);
    wr(4'd12, 16'h0000);
    rd(4'd12, d); chk("snap_l", 32'(d), 32'd900);
    rd(4'd13, d); chk("snap_h", 32'(d), 32'd0);
    wr(4'd9, 16'h000C);
    rd(4'd8, d);  chk("start_stop_status", 32'(d), 32'h0002);
    rd(4'd9, d);  chk("start_stop_ctrl_rb", 32'(d), 32'h0000);
    wr(4'd15, 16'hFFFF);
    rd(4'd15, d); chk("cmp_h_masked", 32'(d), 32'h00FF);

    // ch0 running with irq and PWM high, then async reset
    wr(4'd2, 16'd9);
    wr(4'd3, 16'd0);
    wr(4'd6, 16'd20);
    wr(4'd7, 16'd0);
    wr(4'd1, 16'h0017);
    step(12);
    chk("pre_reset_irq", 32'(irq), 32'h1);
    chk("pre_reset_pwm", 32'(pwm_out[0]), 32'h1);
    rd(4'd2, d); chk("pre_reset_read", 32'(d), 32'd9);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_irq", 32'(irq), 32'h0);
    chk("async_reset_pwm", 32'(pwm_out), 32'h0);
    chk("async_reset_readdata", 32'(bus.readdata), 32'h0);
    step(2);
    reset_n = 1'b1;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
